// File: rtl/booth_digit_decoder.sv
// Radix-4 Booth digit-stream decoder: rebuilds a signed WIDTH-bit operand from NDIG digits, LSD first.
// Optional illegal-code flag (out_err) enabled by defining BOOTH_DEC_ERR_CHECK_EN.
module booth_digit_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
`ifdef BOOTH_DEC_ERR_CHECK_EN
  ,
  output logic             out_err
`endif
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int AW   = WIDTH + 2;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic signed [AW-1:0] r_acc;

  logic [1:0]    w_mag;
  logic          w_neg;
  logic [AW-1:0] w_term;
  logic [AW-1:0] w_next_acc;
  logic          w_accept;
  logic          w_take;
  logic          w_last;
  logic          w_ovf;

  // Illegal codes fall through to magnitude 0, so they add nothing.
  always_comb begin
    w_mag = 2'd0;
    w_neg = 1'b0;
    case (in_digit)
      3'b001: w_mag = 2'd1;
      3'b010: w_mag = 2'd2;
      3'b101: begin w_mag = 2'd1; w_neg = 1'b1; end
      3'b110: begin w_mag = 2'd2; w_neg = 1'b1; end
      default: begin end
    endcase
  end

  assign w_term     = {{(AW-2){1'b0}}, w_mag} << {r_cnt, 1'b0};
  assign w_next_acc = w_neg ? (r_acc - w_term) : (r_acc + w_term);

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_take    = out_valid & out_ready;
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_acc <= w_next_acc;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          if (w_take) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= COLLECT;
          end
        end
      endcase
    end
  end

  // In range iff the bits from the WIDTH-1 sign position upward all agree.
  assign w_ovf    = ~((&r_acc[AW-1:WIDTH-1]) | ~(|r_acc[AW-1:WIDTH-1]));
  assign out_data = r_acc[WIDTH-1:0];
  assign out_ovf  = w_ovf;

`ifdef BOOTH_DEC_ERR_CHECK_EN
  logic r_err;
  logic w_illegal;

  assign w_illegal = (in_digit == 3'b011) | (in_digit == 3'b100) | (in_digit == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end else if (w_take) begin
      r_err <= 1'b0;
    end
  end

  assign out_err = r_err;
`endif

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Scoreboard bench for booth_digit_decoder at WIDTH=8: expected words queued at drive time, popped on output.
module tb_booth_digit_decoder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ovf;
    logic             err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_digit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
`ifdef BOOTH_DEC_ERR_CHECK_EN
  logic             out_err;
`endif

  int   total;
  int   bad;
  exp_t sb[$];

  booth_digit_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
`ifdef BOOTH_DEC_ERR_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dval(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b101:  return -1;
      3'b110:  return -2;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100) || (c == 3'b111);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input logic [2:0] d);
    logic ok;
    int   budget;
    ok = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_digit = d;
    while (!ok && budget < 20) begin
      ok = in_ready;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL digit_accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  // digs = {d3,d2,d1,d0}; d0 is sent first
  task automatic send_word(input logic [11:0] digs, input int gap);
    int   sum;
    int   w;
    exp_t e;
    logic [2:0] c;
    logic [31:0] s32;
    sum = 0;
    w = 1;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = digs[3*i +: 3];
      sum += dval(c) * w;
      w *= 4;
      if (is_illegal(c)) e.err = 1'b1;
    end
    s32 = sum;
    e.data = s32[WIDTH-1:0];
    e.ovf = (sum < -128) || (sum > 127);
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) tick();
      end
      drive_digit(digs[3*i +: 3]);
    end
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL latency: out_valid=%b in_ready=%b, required 1/0 after last digit", out_valid, in_ready);
    end
  endtask

  task automatic check_word(input string nm, input exp_t e);
    total++;
    if (out_data !== e.data || out_ovf !== e.ovf) begin
      bad++;
      $display("FAIL %s: data=%h ovf=%b, required data=%h ovf=%b", nm, out_data, out_ovf, e.data, e.ovf);
    end
`ifdef BOOTH_DEC_ERR_CHECK_EN
    total++;
    if (out_err !== e.err) begin
      bad++;
      $display("FAIL %s_err: out_err=%b, required %b", nm, out_err, e.err);
    end
`endif
  endtask

  task automatic collect(input string nm, input int stall, input logic offer);
    exp_t e;
    int   budget;
    budget = 0;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    if (sb.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s_sb: scoreboard empty, required an entry", nm);
      return;
    end
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid_timeout: out_valid=%b, required 1", nm, out_valid);
    end
    check_word(nm, e);
    for (int s = 0; s < stall; s++) begin
      in_valid = offer;
      in_digit = 3'b001;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_stall: out_valid=%b in_ready=%b, required 1/0", nm, out_valid, in_ready);
      end
      check_word({nm, "_stall"}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      bad++;
      $display("FAIL %s_take: out_valid=%b in_ready=%b data=%h, required 0/1/00", nm, out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b data=%h ovf=%b, required 1/0/00/0", in_ready, out_valid, out_data, out_ovf);
    end
`ifdef BOOTH_DEC_ERR_CHECK_EN
    total++;
    if (out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: out_err=%b, required 0", out_err);
    end
`endif
  endtask

  task automatic test_basic();
    send_word({3'b000, 3'b000, 3'b000, 3'b101}, 0);
    collect("minus_one", 0, 1'b0);
  endtask

  task automatic test_boundaries();
    send_word({3'b010, 3'b000, 3'b000, 3'b101}, 0);
    collect("max_pos", 0, 1'b0);
    send_word({3'b110, 3'b000, 3'b000, 3'b000}, 0);
    collect("min_neg", 0, 1'b0);
  endtask

  task automatic test_overflow();
    send_word({3'b010, 3'b010, 3'b010, 3'b010}, 0);
    collect("ovf_pos", 0, 1'b0);
    send_word({3'b110, 3'b110, 3'b110, 3'b110}, 1);
    collect("ovf_neg", 0, 1'b0);
    send_word({3'b010, 3'b000, 3'b000, 3'b001}, 0);
    collect("ovf_just", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_word({3'b000, 3'b001, 3'b000, 3'b010}, 0);
    collect("stall", 3, 1'b1);
    send_word({3'b000, 3'b000, 3'b000, 3'b001}, 0);
    collect("after_stall", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_digit(3'b010);
    drive_digit(3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b vld=%b data=%h, required 1/0/00", in_ready, out_valid, out_data);
    end
    send_word({3'b000, 3'b000, 3'b000, 3'b001}, 0);
    collect("post_reset", 0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_digit(3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: vld=%b data=%h ovf=%b, required 0/00/0", out_valid, out_data, out_ovf);
    end
  endtask

  task automatic test_random();
    logic [11:0] digs;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) digs[3*i +: 3] = 3'($urandom_range(0, 7));
      send_word(digs, int'($urandom_range(0, 2)));
      collect("random", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    send_word({3'b101, 3'b001, 3'b110, 3'b010}, 0);
    collect("b2b_0", 0, 1'b0);
    send_word({3'b001, 3'b101, 3'b010, 3'b110}, 0);
    collect("b2b_1", 0, 1'b0);
  endtask

`ifdef BOOTH_DEC_ERR_CHECK_EN
  task automatic test_err();
    send_word({3'b000, 3'b000, 3'b001, 3'b011}, 0);
    collect("err_word", 0, 1'b0);
    send_word({3'b000, 3'b000, 3'b000, 3'b001}, 0);
    collect("clean_word", 0, 1'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_digit = 3'b000;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_boundaries();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef BOOTH_DEC_ERR_CHECK_EN
    test_err();
`endif
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
